// File: rtl/serial_sub_5_1_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and the
// default operand width it has in common with the registered ripple adder.
package serial_sub_5_1_pkg;

  localparam int DEFAULT_WIDTH = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/serial_sub_5_1_fs.sv
// One-bit full subtractor cell: Diff = A - B - Bin, Bout = borrow out.
module serial_sub_5_1_fs (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic Diff,
  output logic Bout
);

  assign Diff = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_sub_5_1.sv
// Bit-serial subtractor D = A - B, LSB first, one bit per clock through a
// single full-subtractor cell. Optional ovf output under SERIAL_SUB_OVF_EN.
module serial_sub_5_1
  import serial_sub_5_1_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int              CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   d_sh_q, d_sh_d;
  logic               brw_q, brw_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic               bout_q, bout_d;
  logic               done_q, done_d;
  logic               fs_diff, fs_bout;
  logic [WIDTH-1:0]   d_shift;
  logic               last_bit;
`ifdef SERIAL_SUB_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  serial_sub_5_1_fs u_fs (
    .A    (a_sh_q[0]),
    .B    (b_sh_q[0]),
    .Bin  (brw_q),
    .Diff (fs_diff),
    .Bout (fs_bout)
  );

  // New difference bit enters at the MSB; after WIDTH shifts bit 0 lands in D[0].
  assign d_shift  = (d_sh_q >> 1) | (WIDTH'(fs_diff) << (WIDTH - 1));
  assign last_bit = (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
        else       state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (last_bit) state_d = ST_IDLE;
        else          state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_RUN);
  end

  always_comb begin
    a_sh_d = a_sh_q;
    b_sh_d = b_sh_q;
    d_sh_d = d_sh_q;
    brw_d  = brw_q;
    cnt_d  = cnt_q;
    d_d    = d_q;
    bout_d = bout_q;
    done_d = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d  = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sh_d = A;
          b_sh_d = B;
          brw_d  = 1'b0;
          cnt_d  = '0;
        end else begin
          a_sh_d = a_sh_q;
        end
      end
      ST_RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        d_sh_d = d_shift;
        brw_d  = fs_bout;
        cnt_d  = cnt_q + CNT_W'(1);
        if (last_bit) begin
          d_d    = d_shift;
          bout_d = fs_bout;
          done_d = 1'b1;
`ifdef SERIAL_SUB_OVF_EN
          // Signed overflow: borrow into the sign stage differs from borrow out of it.
          ovf_d  = brw_q ^ fs_bout;
`endif
        end else begin
          done_d = 1'b0;
        end
      end
      default: done_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q <= '0;
      b_sh_q <= '0;
      d_sh_q <= '0;
      brw_q  <= 1'b0;
      cnt_q  <= '0;
      d_q    <= '0;
      bout_q <= 1'b0;
      done_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      a_sh_q <= a_sh_d;
      b_sh_q <= b_sh_d;
      d_sh_q <= d_sh_d;
      brw_q  <= brw_d;
      cnt_q  <= cnt_d;
      d_q    <= d_d;
      bout_q <= bout_d;
      done_q <= done_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q  <= ovf_d;
`endif
    end
  end

  assign done = done_q;
  assign D    = d_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
